// File: rtl/seq_mult_sched.sv
// Round-robin scheduler sharing one sequential multiplier among NREQ requesters.
// Each job: grant in IDLE, pulse mul_reset, wait for rdy (or timeout), hold the response.
module seq_mult_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_p,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 mul_reset,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    input  logic [31:0]          mul_p,
    input  logic                 mul_rdy
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic [2:0]    rr_ptr_q, rr_ptr_d;
    logic [2:0]    grant_id_q, grant_id_d;
    logic [15:0]   mul_a_q, mul_a_d;
    logic [15:0]   mul_b_q, mul_b_d;
    logic [31:0]   rsp_p_q, rsp_p_d;
    logic          rsp_err_q, rsp_err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          found;
    logic [2:0]    sel;
    logic [15:0]   sel_a, sel_b;
    logic          own_ready;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!found && req_valid[i] && ((32'(rr_ptr_q) + k) % NREQ == i)) begin
                    found = 1'b1;
                    sel   = 3'(i);
                end
            end
        end
    end

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        own_ready = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (sel == 3'(i)) begin
                sel_a = req_a[16*i +: 16];
                sel_b = req_b[16*i +: 16];
            end
            if (grant_id_q == 3'(i)) begin
                own_ready = rsp_ready[i];
            end
        end
    end

    // req_ready is gated by resetn so a handshake can never be seen while reset wins.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready[i] = resetn && (state_q == StIdle) && found && (sel == 3'(i));
            rsp_valid[i] = (state_q == StResp) && (grant_id_q == 3'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        rsp_p_d    = rsp_p_q;
        rsp_err_d  = rsp_err_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_id_d = sel;
                    mul_a_d    = sel_a;
                    mul_b_d    = sel_b;
                    state_d    = StStart;
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + CW'(1);
                // rdy in the first WAIT cycle may still be left over from the previous job.
                if ((cnt_q != '0) && mul_rdy) begin
                    rsp_p_d   = mul_p;
                    rsp_err_d = 1'b0;
                    state_d   = StResp;
                end else if (cnt_d == CW'(TIMEOUT)) begin
                    rsp_p_d   = '0;
                    rsp_err_d = 1'b1;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (own_ready) begin
                    rr_ptr_d = (grant_id_q == 3'(NREQ - 1)) ? 3'd0 : grant_id_q + 3'd1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            rsp_p_q    <= '0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            rsp_p_q    <= rsp_p_d;
            rsp_err_q  <= rsp_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign mul_reset = (state_q == StStart);
    assign grant_id  = grant_id_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_p     = rsp_p_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_seq_mult_sched.sv
// Directed bench for seq_mult_sched with a behavioural multiplier stub.
// Stub latency, stale-rdy and never-ready behaviour are set per scenario.
module tb_seq_mult_sched;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready = '0;
    logic [31:0] rsp_p;
    logic        rsp_err;
    logic        busy;
    logic [2:0]  grant_id;
    logic        mul_reset;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [31:0] mul_p = '0;
    logic        mul_rdy = 1'b0;

    int total = 0;
    int bad = 0;

    int lat = 5;
    bit stale = 1'b0;
    bit never = 1'b0;
    int scnt = 0;
    bit srun = 1'b0;

    seq_mult_sched #(.NREQ(4), .TIMEOUT(64)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .grant_id  (grant_id),
        .mul_reset (mul_reset),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .mul_rdy   (mul_rdy)
    );

    always #5 clk = ~clk;

    // Multiplier stub: rdy rises lat cycles after the reset pulse and stays high until the next one.
    always @(posedge clk) begin
        if (mul_reset) begin
            scnt    <= 0;
            srun    <= 1'b1;
            mul_rdy <= stale;
            mul_p   <= stale ? 32'hDEADBEEF : 32'h0;
        end else if (srun) begin
            scnt    <= scnt + 1;
            mul_rdy <= 1'b0;
            if (!never && (scnt + 1 == lat)) begin
                mul_rdy <= 1'b1;
                mul_p   <= {16'h0, mul_a} * {16'h0, mul_b};
                srun    <= 1'b0;
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    // Called at a negedge; returns at the negedge where req_ready is seen.
    task automatic wait_ready(output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (n < 300) begin
            if (req_ready != 4'b0) begin
                ok = 1'b1;
                break;
            end
            next();
            samp();
            n++;
        end
    endtask

    task automatic wait_rsp(output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (n < 300) begin
            if (rsp_valid != 4'b0) begin
                ok = 1'b1;
                break;
            end
            next();
            samp();
            n++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        next();
        next();
        resetn = 1'b1;
        samp();
        total++;
        if ({busy, mul_reset, rsp_err, grant_id, rsp_valid, req_ready} !== 14'h0) begin
            bad++;
            $display("FAIL reset_ctrl: got busy=%b mrst=%b err=%b gid=%0d rv=%b rr=%b, want all 0",
                     busy, mul_reset, rsp_err, grant_id, rsp_valid, req_ready);
        end
        total++;
        if ({mul_a, mul_b, rsp_p} !== 64'h0) begin
            bad++;
            $display("FAIL reset_data: got a=%h b=%h p=%h, want 0", mul_a, mul_b, rsp_p);
        end
        next();
    endtask

    task automatic test_single();
        int n;
        bit ok;
        lat = 5;
        set_op(0, 16'd3, 16'd7);
        rsp_ready = 4'b0001;
        req_valid = 4'b0001;
        samp();
        wait_ready(n, ok);
        total++;
        if (!ok || n != 0 || req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL single_ready: got ok=%b n=%0d rr=%b, want n=0 rr=0001", ok, n, req_ready);
        end
        next();
        req_valid = '0;
        samp();
        total++;
        if ({mul_reset, busy, grant_id, mul_a, mul_b} !== {1'b1, 1'b1, 3'd0, 16'd3, 16'd7}) begin
            bad++;
            $display("FAIL single_start: got mrst=%b busy=%b gid=%0d a=%0d b=%0d, want 1 1 0 3 7",
                     mul_reset, busy, grant_id, mul_a, mul_b);
        end
        wait_rsp(n, ok);
        total++;
        if (!ok || n + 1 != 8) begin
            bad++;
            $display("FAIL single_latency: got %0d cycles (ok=%b), want 8", n + 1, ok);
        end
        total++;
        if (rsp_valid !== 4'b0001 || rsp_p !== 32'd21 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL single_rsp: got rv=%b p=%0d err=%b, want 0001 21 0",
                     rsp_valid, rsp_p, rsp_err);
        end
        next();
        samp();
        total++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0) begin
            bad++;
            $display("FAIL single_idle: got busy=%b rv=%b, want 0 0000", busy, rsp_valid);
        end
        next();
    endtask

    task automatic test_fairness();
        int n;
        bit ok;
        test_reset();
        lat = 3;
        rsp_ready = 4'hF;
        for (int i = 0; i < 4; i++) set_op(i, 16'(i + 1), 16'd100);
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % 4;
            samp();
            wait_ready(n, ok);
            total++;
            if (!ok || req_ready !== (4'b0001 << e)) begin
                bad++;
                $display("FAIL fair_grant%0d: got rr=%b, want %b", k, req_ready, 4'b0001 << e);
            end
            next();
            if (k == 4) req_valid = '0;
            samp();
            wait_rsp(n, ok);
            total++;
            if (!ok || rsp_valid !== (4'b0001 << e) || rsp_p !== 32'((e + 1) * 100)
                || rsp_err !== 1'b0) begin
                bad++;
                $display("FAIL fair_rsp%0d: got rv=%b p=%0d err=%b, want %b %0d 0",
                         k, rsp_valid, rsp_p, rsp_err, 4'b0001 << e, (e + 1) * 100);
            end
            next();
        end
    endtask

    task automatic test_backpressure();
        int n;
        bit ok;
        lat = 2;
        rsp_ready = '0;
        set_op(1, 16'h1234, 16'h0010);
        set_op(3, 16'hFFFF, 16'hFFFF);
        req_valid = 4'b1010;
        samp();
        wait_ready(n, ok);
        total++;
        if (!ok || req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL bp_grant: got rr=%b, want 0010", req_ready);
        end
        next();
        req_valid = 4'b1000;
        samp();
        wait_rsp(n, ok);
        total++;
        if (!ok || rsp_valid !== 4'b0010 || rsp_p !== 32'h00012340) begin
            bad++;
            $display("FAIL bp_rsp: got rv=%b p=%h, want 0010 00012340", rsp_valid, rsp_p);
        end
        next();
        rsp_ready = 4'b1101;
        for (int c = 0; c < 5; c++) begin
            samp();
            total++;
            if ({rsp_valid, req_ready, busy} !== {4'b0010, 4'b0000, 1'b1}
                || rsp_p !== 32'h00012340 || rsp_err !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d: got rv=%b rr=%b busy=%b p=%h err=%b, want 0010 0000 1 00012340 0",
                         c, rsp_valid, req_ready, busy, rsp_p, rsp_err);
            end
            next();
        end
        rsp_ready = 4'b0010;
        next();
        rsp_ready = 4'hF;
        samp();
        total++;
        if (req_ready !== 4'b1000) begin
            bad++;
            $display("FAIL bp_next_grant: got rr=%b, want 1000", req_ready);
        end
        next();
        req_valid = '0;
        samp();
        wait_rsp(n, ok);
        total++;
        if (!ok || rsp_valid !== 4'b1000 || rsp_p !== 32'hFFFE0001) begin
            bad++;
            $display("FAIL bp_rsp3: got rv=%b p=%h, want 1000 fffe0001", rsp_valid, rsp_p);
        end
        next();
    endtask

    task automatic test_stale();
        int n;
        bit ok;
        stale = 1'b1;
        lat = 17;
        rsp_ready = 4'hF;
        set_op(2, 16'd1000, 16'd50);
        req_valid = 4'b0100;
        samp();
        wait_ready(n, ok);
        total++;
        if (!ok || req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL stale_grant: got rr=%b, want 0100", req_ready);
        end
        next();
        req_valid = '0;
        samp();
        wait_rsp(n, ok);
        total++;
        if (!ok || n + 1 != 20 || rsp_p !== 32'd50000 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL stale_rsp: got cycles=%0d p=%h err=%b, want 20 0000c350 0",
                     n + 1, rsp_p, rsp_err);
        end
        next();
        stale = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        never = 1'b1;
        set_op(0, 16'd5, 16'd6);
        req_valid = 4'b0001;
        samp();
        wait_ready(n, ok);
        total++;
        if (!ok || req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL to_grant: got rr=%b, want 0001", req_ready);
        end
        next();
        req_valid = '0;
        samp();
        wait_rsp(n, ok);
        total++;
        if (!ok || n + 1 != 66 || rsp_valid !== 4'b0001 || rsp_p !== 32'h0 || rsp_err !== 1'b1) begin
            bad++;
            $display("FAIL to_rsp: got cycles=%0d rv=%b p=%h err=%b, want 66 0001 0 1",
                     n + 1, rsp_valid, rsp_p, rsp_err);
        end
        next();
        never = 1'b0;
        lat = 4;
        set_op(1, 16'd9, 16'd9);
        req_valid = 4'b0010;
        samp();
        wait_ready(n, ok);
        total++;
        if (!ok || req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL to_after_grant: got rr=%b, want 0010", req_ready);
        end
        next();
        req_valid = '0;
        samp();
        wait_rsp(n, ok);
        total++;
        if (!ok || n + 1 != 7 || rsp_p !== 32'd81 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL to_after_rsp: got cycles=%0d p=%0d err=%b, want 7 81 0",
                     n + 1, rsp_p, rsp_err);
        end
        next();
    endtask

    task automatic test_reset_mid();
        int n;
        bit ok;
        lat = 3;
        set_op(2, 16'd2, 16'd2);
        req_valid = 4'b0100;
        samp();
        wait_ready(n, ok);
        next();
        req_valid = '0;
        samp();
        wait_rsp(n, ok);
        total++;
        if (!ok || rsp_valid !== 4'b0100 || rsp_p !== 32'd4) begin
            bad++;
            $display("FAIL rm_pre_rsp: got rv=%b p=%0d, want 0100 4", rsp_valid, rsp_p);
        end
        next();
        lat = 10;
        set_op(3, 16'd7, 16'd8);
        req_valid = 4'b1000;
        samp();
        wait_ready(n, ok);
        total++;
        if (!ok || req_ready !== 4'b1000) begin
            bad++;
            $display("FAIL rm_grant3: got rr=%b, want 1000", req_ready);
        end
        next();
        next();
        next();
        set_op(2, 16'd11, 16'd13);
        req_valid = 4'b1100;
        resetn = 1'b0;
        next();
        resetn = 1'b1;
        samp();
        total++;
        if ({busy, mul_reset, rsp_err, grant_id, rsp_valid} !== 10'h0
            || {mul_a, mul_b, rsp_p} !== 64'h0) begin
            bad++;
            $display("FAIL rm_zero: got busy=%b mrst=%b err=%b gid=%0d rv=%b a=%h b=%h p=%h, want 0",
                     busy, mul_reset, rsp_err, grant_id, rsp_valid, mul_a, mul_b, rsp_p);
        end
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL rm_regrant: got rr=%b, want 0100", req_ready);
        end
        next();
        req_valid = '0;
        samp();
        wait_rsp(n, ok);
        total++;
        if (!ok || rsp_valid !== 4'b0100 || rsp_p !== 32'd143 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL rm_rsp: got rv=%b p=%0d err=%b, want 0100 143 0",
                     rsp_valid, rsp_p, rsp_err);
        end
        next();
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_stale();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
